// File: rtl/timer_sched_pkg.sv
// Shared constants and state encoding for the interval-timer tick scheduler.
package timer_sched_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam int         CTRL_ITO    = 0;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ARM_CLR = 3'd1,
    ST_ARM_EN  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_READ    = 3'd5,
    ST_CHECK   = 3'd6,
    ST_DISARM  = 3'd7
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// One frame-tick divider channel: counts steps and emits a registered pulse every div steps.
module tick_divider #(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (step) begin
        if (div == '0) begin
          cnt <= '0;
        // >= so a divisor lowered below the running count wraps on the next step
        end else if (cnt >= div - DIV_W'(1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_tick_sched.sv
// Sole Avalon-MM master of the interval timer: arms it, services each timeout and fans out divided ticks.
module timer_tick_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq,
  output logic                    frame_tick,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [31:0]             tick_count,
  output logic [15:0]             overrun_count,
  output logic [2:0]              state_dbg
);

  // Bus: Avalon-MM without waitrequest; every access lasts exactly one cycle with chipselect
  // high, readdata is taken the cycle after a read. Tick outputs are one-cycle strobes, no ready.

  state_t state, state_nxt;
  logic   div_clr;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:     if (run_en) state_nxt = ST_ARM_CLR;
      ST_ARM_CLR: state_nxt = ST_ARM_EN;
      ST_ARM_EN:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tmr_irq)      state_nxt = ST_CLEAR;
        else if (!run_en) state_nxt = ST_DISARM;
      end
      ST_CLEAR:   state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_CHECK;
      ST_CHECK:   state_nxt = tmr_readdata[0] ? ST_CLEAR : ST_WAIT;
      ST_DISARM:  state_nxt = ST_OFF;
      default:    state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_OFF;
    else       state <= state_nxt;
  end

  // Bus outputs decode straight from state so reset forces them idle in the same cycle
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    case (state)
      ST_ARM_CLR, ST_CLEAR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_STATUS;
      end
      ST_ARM_EN: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_CONTROL;
        tmr_writedata  = 16'(1) << CTRL_ITO;
      end
      ST_READ: begin
        tmr_chipselect = 1'b1;
        tmr_address    = TMR_STATUS;
      end
      ST_DISARM: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_CONTROL;
      end
      default: ;
    endcase
  end

  assign frame_tick = (state == ST_CLEAR);
  assign div_clr    = (state == ST_OFF);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_count    <= 32'd0;
      overrun_count <= 16'd0;
    end else begin
      if (frame_tick) tick_count <= tick_count + 32'd1;
      if (state == ST_CHECK && tmr_readdata[0] && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_div
    tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (div_clr),
      .step  (frame_tick),
      .div   (div_val[c*DIV_W +: DIV_W]),
      .tick  (ch_tick[c])
    );
  end

endmodule

// File: tb/tb_timer_tick_sched.sv
// Bench for timer_tick_sched: behavioural timer slave, expected-write and expected-tick queues.
module tb_timer_tick_sched;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 10;
  localparam int PERIOD = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    run_en;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [2:0]              tmr_address;
  logic                    tmr_chipselect;
  logic                    tmr_write_n;
  logic [15:0]             tmr_writedata;
  logic [15:0]             tmr_readdata;
  logic                    tmr_irq;
  logic                    frame_tick;
  logic [NUM_CH-1:0]       ch_tick;
  logic [31:0]             tick_count;
  logic [15:0]             overrun_count;
  logic [2:0]              state_dbg;

  timer_tick_sched #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .run_en         (run_en),
    .div_val        (div_val),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .frame_tick     (frame_tick),
    .ch_tick        (ch_tick),
    .tick_count     (tick_count),
    .overrun_count  (overrun_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- timer slave model (not reset by DUT reset; starts with a stale TO) ----------------
  logic to_r  = 1'b1;
  logic ito_r = 1'b0;
  logic [15:0] rdata = 16'd0;
  bit   fire_req = 1'b0;
  bit   inject   = 1'b0;

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      if (tmr_address == 3'd0)      to_r  <= inject;
      else if (tmr_address == 3'd1) ito_r <= tmr_writedata[0];
    end else if (fire_req) begin
      to_r <= 1'b1;
    end
    if (tmr_chipselect && tmr_write_n && tmr_address == 3'd0) rdata <= {15'd0, to_r};
    else                                                      rdata <= 16'd0;
  end

  assign tmr_readdata = rdata;
  assign tmr_irq      = to_r & ito_r;

  // ---------------- scoreboard ----------------
  logic [18:0]       exp_q[$];
  logic [NUM_CH-1:0] ch_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_frame = 0;
  int n_bus = 0;
  int n_ch[NUM_CH];
  logic prev_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial foreach (n_ch[i]) n_ch[i] = 0;

  // monitor: bus writes, idle bus values, divided ticks
  always @(negedge clk) begin
    if (tmr_chipselect) n_bus++;
    if (tmr_chipselect && !tmr_write_n) begin
      if (exp_q.size() == 0) check("unexpected_write", {13'd0, tmr_address, tmr_writedata}, 32'hDEAD);
      else                   check("bus_write", {13'd0, tmr_address, tmr_writedata}, {13'd0, exp_q.pop_front()});
    end else if (tmr_chipselect) begin
      check("read_addr", tmr_address, 3'd0);
    end else if (tmr_address != 3'd0 || tmr_writedata != 16'd0 || !tmr_write_n) begin
      check("idle_bus", {tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 3'd0, 16'd0});
    end
    if (frame_tick) n_frame++;
    if (ch_tick != '0) begin
      for (int c = 0; c < NUM_CH; c++) if (ch_tick[c]) n_ch[c]++;
      check("ch_after_frame", prev_frame, 1'b1);
      if (ch_q.size() == 0) check("unexpected_ch_tick", ch_tick, 4'h0);
      else                  check("ch_tick", ch_tick, ch_q.pop_front());
    end
    prev_frame = frame_tick;
  end

  // ---------------- driver tasks ----------------
  task automatic fire(input bit inj);
    exp_q.push_back({3'd0, 16'd0});
    if (inj) exp_q.push_back({3'd0, 16'd0});
    @(negedge clk) begin fire_req = 1'b1; inject = inj; end
    @(negedge clk) fire_req = 1'b0;
    check("irq_raised", tmr_irq, 1'b1);
    @(negedge clk) check("frame_latency", frame_tick, 1'b1);
    if (inj) @(negedge clk) inject = 1'b0;
    repeat (PERIOD) @(negedge clk);
  endtask

  task automatic arm();
    exp_q.push_back({3'd0, 16'd0});
    exp_q.push_back({3'd1, 16'd1});
    @(negedge clk) run_en = 1'b1;
    @(negedge clk) check("arm_clr", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd0});
    @(negedge clk) check("arm_en", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd1, 16'd1});
    @(negedge clk) check("arm_wait", {tmr_chipselect, state_dbg}, {1'b0, 3'd3});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},      tmr_chipselect, 1'b0);
    check({tag, "_write_n"}, tmr_write_n, 1'b1);
    check({tag, "_addr"},    tmr_address, 3'd0);
    check({tag, "_wdata"},   tmr_writedata, 16'd0);
    check({tag, "_frame"},   frame_tick, 1'b0);
    check({tag, "_ch"},      ch_tick, 4'h0);
    check({tag, "_ticks"},   tick_count, 32'd0);
    check({tag, "_overrun"}, overrun_count, 16'd0);
    check({tag, "_state"},   state_dbg, 3'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; run_en = 1'b0; div_val = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst");
    repeat (100) @(negedge clk);
    check("idle_100_bus", n_bus, 0);

    // arm; the stale TO is cleared, so nothing fires during a quiet period
    arm();
    repeat (PERIOD) @(negedge clk);
    check("stale_to_no_tick", n_frame, 0);

    repeat (3) fire(1'b0);
    check("ticks_3", tick_count, 32'd3);
    check("overrun_0", overrun_count, 16'd0);
    check("frames_3", n_frame, 3);

    // channels 3..0 divide by 0,3,2,1
    div_val = {10'd0, 10'd3, 10'd2, 10'd1};
    ch_q.push_back(4'b0001); ch_q.push_back(4'b0011); ch_q.push_back(4'b0101);
    ch_q.push_back(4'b0011); ch_q.push_back(4'b0001); ch_q.push_back(4'b0111);
    repeat (6) fire(1'b0);
    check("ticks_9", tick_count, 32'd9);
    check("ch0_count", n_ch[0], 6);
    check("ch1_count", n_ch[1], 3);
    check("ch2_count", n_ch[2], 2);
    check("ch3_count", n_ch[3], 0);

    // TO still pending on the post-clear read: overrun and a second tick
    ch_q.push_back(4'b0001); ch_q.push_back(4'b0011);
    fire(1'b1);
    check("overrun_1", overrun_count, 16'd1);
    check("ticks_11", tick_count, 32'd11);
    check("overrun_back_wait", state_dbg, 3'd3);

    // disarm
    exp_q.push_back({3'd1, 16'd0});
    @(negedge clk) run_en = 1'b0;
    @(negedge clk) check("disarm_write", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 1'b0, 3'd1, 16'd0});
    @(negedge clk) check("disarm_off", state_dbg, 3'd0);

    // re-arm: ch2 would pulse here had its count (2) not been cleared in OFF
    arm();
    ch_q.push_back(4'b0001);
    fire(1'b0);
    check("ticks_12", tick_count, 32'd12);

    // reset lands in READ of a service sequence
    exp_q.push_back({3'd0, 16'd0});
    @(negedge clk) fire_req = 1'b1;
    @(negedge clk) fire_req = 1'b0;
    @(negedge clk) check("pre_reset_clear", frame_tick, 1'b1);
    @(posedge clk) #1 check("in_read", state_dbg, 3'd5);
    reset = 1'b1; run_en = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_off", state_dbg, 3'd0);
    arm();
    ch_q.push_back(4'b0001);
    fire(1'b0);
    check("ticks_after_reset", tick_count, 32'd1);
    check("overrun_after_reset", overrun_count, 16'd0);

    repeat (5) @(negedge clk);
    check("write_q_drained", exp_q.size(), 0);
    check("ch_q_drained", ch_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
